axi_lite_slave_ram: RTL and testbench

AXI-Lite responder (slave) backed by a word-addressed on-chip RAM. It is the bus end that the core's no-cache data path and the holy_core_pkg AXI-Lite masters talk to. It is used in simulation benches and as a small scratchpad/peripheral RAM in the SoC. Read and write channels are independent FSMs with a programmable read latency and SLVERR on out-of-range addresses.

---
 rtl/axi_lite_slave_ram.sv | 205 ++++++++++++++++++++
 tb/tb_axi_lite_slave_ram.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_ram.sv
// AXI-Lite responder backed by a word-addressed RAM. Write and read channels are
// independent FSMs; reads have a programmable latency; out-of-window accesses get SLVERR.
//
// state  | meaning
// W_IDLE | collecting AW and W halves, in either order or together
// W_RESP | write committed, bvalid held until bready
// R_IDLE | arready high, waiting for an AR handshake
// R_WAIT | latency counter running down to its terminal count
// R_DATA | rdata/rresp captured, rvalid held until rready
module axi_lite_slave_ram #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int          SIZE_WORDS   = 1024,
   parameter int          READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] axi_lite_awaddr,
   input  logic        axi_lite_awvalid,
   output logic        axi_lite_awready,
   input  logic [31:0] axi_lite_wdata,
   input  logic [3:0]  axi_lite_wstrb,
   input  logic        axi_lite_wvalid,
   output logic        axi_lite_wready,
   output logic [1:0]  axi_lite_bresp,
   output logic        axi_lite_bvalid,
   input  logic        axi_lite_bready,
   input  logic [31:0] axi_lite_araddr,
   input  logic        axi_lite_arvalid,
   output logic        axi_lite_arready,
   output logic [31:0] axi_lite_rdata,
   output logic [1:0]  axi_lite_rresp,
   output logic        axi_lite_rvalid,
   input  logic        axi_lite_rready
);

   localparam int          IDX_W       = $clog2(SIZE_WORDS);
   localparam logic [32:0] SPAN        = 33'(SIZE_WORDS) * 33'd4;
   localparam logic [3:0]  LAT_LOAD    = 4'(READ_LATENCY - 1);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

   logic [31:0] mem_q [SIZE_WORDS];

   w_state_e    w_state_q;
   logic        aw_held_q, w_held_q;
   logic [31:0] awaddr_q, wdata_q;
   logic [3:0]  wstrb_q;
   logic        awready_q, wready_q, bvalid_q;
   logic [1:0]  bresp_q;

   r_state_e    r_state_q;
   logic [3:0]  cnt_q;
   logic [31:0] araddr_q, rdata_q;
   logic [1:0]  rresp_q;
   logic        arready_q, rvalid_q;

   logic              aw_hs, w_hs, aw_have, w_have, commit;
   logic [31:0]       wr_addr, wr_data;
   logic [3:0]        wr_strb;
   logic [32:0]       wr_diff;
   logic              wr_hit;
   logic [IDX_W-1:0]  wr_idx;

   logic              ar_hs, capture;
   logic [31:0]       rd_addr, cap_data;
   logic [32:0]       rd_diff;
   logic              rd_hit;
   logic [IDX_W-1:0]  rd_idx;

   // A half that handshakes on the commit edge is used directly from the bus.
   assign aw_hs   = axi_lite_awvalid && awready_q;
   assign w_hs    = axi_lite_wvalid && wready_q;
   assign aw_have = aw_held_q || aw_hs;
   assign w_have  = w_held_q || w_hs;
   assign commit  = (w_state_q == W_IDLE) && aw_have && w_have;
   assign wr_addr = aw_hs ? axi_lite_awaddr : awaddr_q;
   assign wr_data = w_hs ? axi_lite_wdata : wdata_q;
   assign wr_strb = w_hs ? axi_lite_wstrb : wstrb_q;

   // 33-bit offset: an address below BASE_ADDR wraps to a huge value and misses.
   assign wr_diff = {1'b0, wr_addr} - {1'b0, BASE_ADDR};
   assign wr_hit  = wr_diff < SPAN;
   assign wr_idx  = wr_diff[IDX_W+1:2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q <= W_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         case (w_state_q)
            W_IDLE: begin
               if (aw_hs) awaddr_q <= axi_lite_awaddr;
               if (w_hs) begin
                  wdata_q <= axi_lite_wdata;
                  wstrb_q <= axi_lite_wstrb;
               end
               if (commit) begin
                  w_state_q <= W_RESP;
                  aw_held_q <= 1'b1;
                  w_held_q  <= 1'b1;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= wr_hit ? RESP_OKAY : RESP_SLVERR;
               end else begin
                  aw_held_q <= aw_have;
                  w_held_q  <= w_have;
                  awready_q <= !aw_have;
                  wready_q  <= !w_have;
               end
            end
            W_RESP: begin
               if (axi_lite_bready) begin
                  w_state_q <= W_IDLE;
                  aw_held_q <= 1'b0;
                  w_held_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  bvalid_q  <= 1'b0;
               end
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (commit && wr_hit) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_strb[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   assign ar_hs    = axi_lite_arvalid && arready_q;
   assign rd_addr  = (r_state_q == R_IDLE) ? axi_lite_araddr : araddr_q;
   assign rd_diff  = {1'b0, rd_addr} - {1'b0, BASE_ADDR};
   assign rd_hit   = rd_diff < SPAN;
   assign rd_idx   = rd_diff[IDX_W+1:2];
   assign cap_data = rd_hit ? mem_q[rd_idx] : 32'h0;
   // Capture reads the pre-edge RAM, so a write committing on the same edge is not seen.
   assign capture  = ((r_state_q == R_IDLE) && ar_hs && (LAT_LOAD == 4'd0)) ||
                     ((r_state_q == R_WAIT) && (cnt_q == 4'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q <= R_IDLE;
         cnt_q     <= '0;
         araddr_q  <= '0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
      end else begin
         if (capture) begin
            r_state_q <= R_DATA;
            rvalid_q  <= 1'b1;
            rdata_q   <= cap_data;
            rresp_q   <= rd_hit ? RESP_OKAY : RESP_SLVERR;
         end
         case (r_state_q)
            R_IDLE: begin
               if (ar_hs) begin
                  araddr_q  <= axi_lite_araddr;
                  cnt_q     <= LAT_LOAD;
                  arready_q <= 1'b0;
                  if (LAT_LOAD != 4'd0) r_state_q <= R_WAIT;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_WAIT: cnt_q <= cnt_q - 4'd1;
            R_DATA: begin
               if (axi_lite_rready) begin
                  r_state_q <= R_IDLE;
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
               end
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   assign axi_lite_awready = awready_q;
   assign axi_lite_wready  = wready_q;
   assign axi_lite_bvalid  = bvalid_q;
   assign axi_lite_bresp   = bresp_q;
   assign axi_lite_arready = arready_q;
   assign axi_lite_rvalid  = rvalid_q;
   assign axi_lite_rdata   = rdata_q;
   assign axi_lite_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave_ram.sv
// Bench for axi_lite_slave_ram: two instances (read latency 1 and 4) driven by
// directed and randomized transactions, checked against a per-instance RAM model.
module tb_axi_lite_slave_ram;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [1:0][31:0] awaddr, wdata, araddr, rdata;
   logic [1:0]       awvalid, awready, wvalid, wready, bvalid, bready;
   logic [1:0]       arvalid, arready, rvalid, rready;
   logic [1:0][3:0]  wstrb;
   logic [1:0][1:0]  bresp, rresp;

   int checks = 0;
   int failures = 0;
   int cyc_cnt = 0;

   logic [31:0] mdl [2][1024];

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt++;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      axi_lite_slave_ram #(
         .BASE_ADDR   (32'h0000_0000),
         .SIZE_WORDS  (1024),
         .READ_LATENCY((g == 0) ? 1 : 4)
      ) u_dut (
         .clk             (clk),
         .rst_n           (rst_n),
         .axi_lite_awaddr (awaddr[g]),
         .axi_lite_awvalid(awvalid[g]),
         .axi_lite_awready(awready[g]),
         .axi_lite_wdata  (wdata[g]),
         .axi_lite_wstrb  (wstrb[g]),
         .axi_lite_wvalid (wvalid[g]),
         .axi_lite_wready (wready[g]),
         .axi_lite_bresp  (bresp[g]),
         .axi_lite_bvalid (bvalid[g]),
         .axi_lite_bready (bready[g]),
         .axi_lite_araddr (araddr[g]),
         .axi_lite_arvalid(arvalid[g]),
         .axi_lite_arready(arready[g]),
         .axi_lite_rdata  (rdata[g]),
         .axi_lite_rresp  (rresp[g]),
         .axi_lite_rvalid (rvalid[g]),
         .axi_lite_rready (rready[g])
      );
   end

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 4;
   endfunction

   function automatic logic [1:0] exp_resp(input logic [31:0] a);
      return (a < 32'h1000) ? 2'b00 : 2'b10;
   endfunction

   function automatic logic [31:0] exp_rdata(input int d, input logic [31:0] a);
      return (a < 32'h1000) ? mdl[d][a[11:2]] : 32'h0;
   endfunction

   function automatic void mdl_write(input int d, input logic [31:0] a,
                                     input logic [31:0] dat, input logic [3:0] s);
      if (a < 32'h1000) begin
         for (int i = 0; i < 4; i++) begin
            if (s[i]) mdl[d][a[11:2]][8*i +: 8] = dat[8*i +: 8];
         end
      end
   endfunction

   // Called at a negedge; returns at the negedge after the bready edge.
   task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] dat,
                           input logic [3:0] s, input int w_dly, input int aw_dly, input int bp,
                           output logic [1:0] resp, output int lat,
                           output bit order_ok, output bit hold_ok);
      bit aw_done, w_done, aw_now, w_now;
      int cyc;
      aw_done = 0; w_done = 0; cyc = 0; order_ok = 1; hold_ok = 1;
      while (!(aw_done && w_done) && cyc < 40) begin
         if (!aw_done && cyc >= aw_dly) begin awaddr[d] = a; awvalid[d] = 1'b1; end
         if (!w_done && cyc >= w_dly) begin wdata[d] = dat; wstrb[d] = s; wvalid[d] = 1'b1; end
         aw_now = awvalid[d] && awready[d];
         w_now  = wvalid[d] && wready[d];
         @(negedge clk);
         if (aw_now) begin aw_done = 1; awvalid[d] = 1'b0; end
         if (w_now) begin w_done = 1; wvalid[d] = 1'b0; end
         if (aw_done != w_done) begin
            if ((aw_done && awready[d]) || (w_done && wready[d]) || bvalid[d]) order_ok = 0;
         end
         cyc++;
      end
      awvalid[d] = 1'b0; wvalid[d] = 1'b0;
      lat = 1;
      while (!bvalid[d] && lat < 40) begin @(negedge clk); lat++; end
      resp = bresp[d];
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         if (!bvalid[d] || bresp[d] !== resp || awready[d] || wready[d]) hold_ok = 0;
      end
      bready[d] = 1'b1;
      @(negedge clk);
      bready[d] = 1'b0;
   endtask

   task automatic do_read(input int d, input logic [31:0] a, input int bp,
                          output logic [31:0] dat, output logic [1:0] resp,
                          output int lat, output bit hold_ok);
      int n;
      hold_ok = 1;
      araddr[d] = a; arvalid[d] = 1'b1;
      n = 0;
      while (!arready[d] && n < 40) begin @(negedge clk); n++; end
      @(negedge clk);
      arvalid[d] = 1'b0;
      lat = 1;
      while (!rvalid[d] && lat < 40) begin @(negedge clk); lat++; end
      dat = rdata[d]; resp = rresp[d];
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         if (!rvalid[d] || rdata[d] !== dat || rresp[d] !== resp || arready[d]) hold_ok = 0;
      end
      rready[d] = 1'b1;
      @(negedge clk);
      rready[d] = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({awready[d], wready[d], bvalid[d], arready[d], rvalid[d], bresp[d], rresp[d], rdata[d]} !== '0) begin
            failures++;
            $display("FAIL reset_outputs d%0d: got rdy/val %b%b%b%b%b bresp %b rresp %b rdata %h, expected all 0",
                     d, awready[d], wready[d], bvalid[d], arready[d], rvalid[d], bresp[d], rresp[d], rdata[d]);
         end
      end
      rst_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({awready[d], wready[d], arready[d]} !== 3'b000) begin
            failures++;
            $display("FAIL first_cycle_ready d%0d: got %b expected 000", d, {awready[d], wready[d], arready[d]});
         end
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({awready[d], wready[d], arready[d]} !== 3'b111) begin
            failures++;
            $display("FAIL second_cycle_ready d%0d: got %b expected 111", d, {awready[d], wready[d], arready[d]});
         end
      end
   endtask

   task automatic test_basic;
      logic [1:0] resp; logic [31:0] dat; int lat; bit ok1, ok2;
      do_write(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, resp, lat, ok1, ok2);
      mdl_write(0, 32'h10, 32'hDEAD_BEEF, 4'hF);
      checks++;
      if (resp !== 2'b00 || lat !== 1) begin
         failures++; $display("FAIL basic_write: got bresp %b lat %0d expected 00 lat 1", resp, lat);
      end
      checks++;
      if (bvalid[0] !== 1'b0) begin
         failures++; $display("FAIL basic_bvalid_drop: got %b expected 0", bvalid[0]);
      end
      do_read(0, 32'h10, 0, dat, resp, lat, ok1);
      checks++;
      if (dat !== exp_rdata(0, 32'h10) || resp !== 2'b00 || lat !== 1) begin
         failures++;
         $display("FAIL basic_read: got %h/%b lat %0d expected %h/00 lat 1", dat, resp, lat, exp_rdata(0, 32'h10));
      end
   endtask

   task automatic test_w_before_aw;
      logic [1:0] resp; logic [31:0] dat; int lat; bit order_ok, hold_ok;
      do_write(0, 32'h10, 32'h1122_3344, 4'b0101, 0, 3, 0, resp, lat, order_ok, hold_ok);
      mdl_write(0, 32'h10, 32'h1122_3344, 4'b0101);
      checks++;
      if (order_ok !== 1'b1 || resp !== 2'b00 || lat !== 1) begin
         failures++;
         $display("FAIL w_before_aw: got order_ok %0d bresp %b lat %0d expected 1/00/1", order_ok, resp, lat);
      end
      do_read(0, 32'h10, 0, dat, resp, lat, hold_ok);
      checks++;
      if (dat !== exp_rdata(0, 32'h10) || resp !== 2'b00) begin
         failures++; $display("FAIL w_before_aw_read: got %h expected %h", dat, exp_rdata(0, 32'h10));
      end
   endtask

   task automatic test_out_of_range;
      logic [1:0] resp; logic [31:0] dat; int lat; bit ok1, ok2;
      logic [31:0] oor [3];
      oor[0] = 32'h0000_1000; oor[1] = 32'h0000_1FFC; oor[2] = 32'hFFFF_FFFC;
      do_write(0, 32'h0, 32'hA5A5_0F0F, 4'hF, 0, 0, 0, resp, lat, ok1, ok2);
      mdl_write(0, 32'h0, 32'hA5A5_0F0F, 4'hF);
      do_write(0, 32'hFFF, 32'h0BAD_F00D, 4'hF, 1, 0, 0, resp, lat, ok1, ok2);
      mdl_write(0, 32'hFFF, 32'h0BAD_F00D, 4'hF);
      checks++;
      if (resp !== exp_resp(32'hFFF)) begin
         failures++; $display("FAIL last_word_bresp: got %b expected 00", resp);
      end
      for (int i = 0; i < 3; i++) begin
         do_write(0, oor[i], 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp, lat, ok1, ok2);
         checks++;
         if (resp !== exp_resp(oor[i])) begin
            failures++; $display("FAIL oor_bresp %h: got %b expected 10", oor[i], resp);
         end
         do_read(0, oor[i], 0, dat, resp, lat, ok1);
         checks++;
         if (resp !== exp_resp(oor[i]) || dat !== 32'h0) begin
            failures++; $display("FAIL oor_read %h: got %h/%b expected 0/10", oor[i], dat, resp);
         end
      end
      do_write(0, 32'hFFC, 32'h1234_5678, 4'h0, 0, 0, 0, resp, lat, ok1, ok2);
      checks++;
      if (resp !== 2'b00) begin
         failures++; $display("FAIL zero_strb_bresp: got %b expected 00", resp);
      end
      do_read(0, 32'h0, 0, dat, resp, lat, ok1);
      checks++;
      if (dat !== exp_rdata(0, 32'h0)) begin
         failures++; $display("FAIL oor_no_alias: got %h expected %h", dat, exp_rdata(0, 32'h0));
      end
      do_read(0, 32'hFFE, 0, dat, resp, lat, ok1);
      checks++;
      if (dat !== exp_rdata(0, 32'hFFC) || resp !== 2'b00) begin
         failures++; $display("FAIL last_word_read: got %h/%b expected %h/00", dat, resp, exp_rdata(0, 32'hFFC));
      end
   endtask

   task automatic test_backpressure;
      logic [1:0] resp; logic [31:0] dat; int lat; bit order_ok, hold_ok;
      do_write(0, 32'h40, 32'hCAFE_0001, 4'hF, 0, 0, 5, resp, lat, order_ok, hold_ok);
      mdl_write(0, 32'h40, 32'hCAFE_0001, 4'hF);
      checks++;
      if (hold_ok !== 1'b1 || resp !== 2'b00) begin
         failures++; $display("FAIL bp_write: got hold_ok %0d bresp %b expected 1/00", hold_ok, resp);
      end
      do_read(0, 32'h40, 5, dat, resp, lat, hold_ok);
      checks++;
      if (hold_ok !== 1'b1 || dat !== exp_rdata(0, 32'h40)) begin
         failures++;
         $display("FAIL bp_read: got hold_ok %0d rdata %h expected 1/%h", hold_ok, dat, exp_rdata(0, 32'h40));
      end
   endtask

   task automatic test_back_to_back;
      logic [1:0] resp; logic [31:0] dat, v; int lat, start; bit ok1, ok2;
      start = cyc_cnt;
      for (int i = 0; i < 4; i++) begin
         v = $urandom;
         do_write(0, 32'h80 + 32'(4*i), v, 4'hF, 0, 0, 0, resp, lat, ok1, ok2);
         mdl_write(0, 32'h80 + 32'(4*i), v, 4'hF);
      end
      checks++;
      if (cyc_cnt - start > 12) begin
         failures++; $display("FAIL b2b_throughput: got %0d cycles for 4 writes expected <= 12", cyc_cnt - start);
      end
      for (int i = 0; i < 4; i++) begin
         do_read(0, 32'h80 + 32'(4*i), 0, dat, resp, lat, ok1);
         checks++;
         if (dat !== exp_rdata(0, 32'h80 + 32'(4*i))) begin
            failures++; $display("FAIL b2b_read %0d: got %h expected %h", i, dat, exp_rdata(0, 32'h80 + 32'(4*i)));
         end
      end
   endtask

   task automatic test_latency4_collision;
      logic [1:0] resp; logic [31:0] dat, old_v, new_v; int lat; bit ok1, ok2;
      old_v = $urandom; new_v = ~old_v;
      do_write(1, 32'h20, old_v, 4'hF, 0, 0, 0, resp, lat, ok1, ok2);
      mdl_write(1, 32'h20, old_v, 4'hF);
      araddr[1] = 32'h20; arvalid[1] = 1'b1;
      @(negedge clk);
      arvalid[1] = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (rvalid[1] !== 1'b0) begin
         failures++; $display("FAIL lat4_early: got rvalid %b 3 cycles after AR expected 0", rvalid[1]);
      end
      awaddr[1] = 32'h20; wdata[1] = new_v; wstrb[1] = 4'hF;
      awvalid[1] = 1'b1; wvalid[1] = 1'b1;
      @(negedge clk);
      awvalid[1] = 1'b0; wvalid[1] = 1'b0;
      checks++;
      if (rvalid[1] !== 1'b1 || rdata[1] !== exp_rdata(1, 32'h20) || rresp[1] !== 2'b00 || bvalid[1] !== 1'b1) begin
         failures++;
         $display("FAIL lat4_collision: got rvalid %b rdata %h bvalid %b expected 1 %h 1",
                  rvalid[1], rdata[1], bvalid[1], exp_rdata(1, 32'h20));
      end
      mdl_write(1, 32'h20, new_v, 4'hF);
      bready[1] = 1'b1; rready[1] = 1'b1;
      @(negedge clk);
      bready[1] = 1'b0; rready[1] = 1'b0;
      do_read(1, 32'h20, 0, dat, resp, lat, ok1);
      checks++;
      if (dat !== exp_rdata(1, 32'h20) || lat !== 4) begin
         failures++; $display("FAIL lat4_reread: got %h lat %0d expected %h lat 4", dat, lat, exp_rdata(1, 32'h20));
      end
   endtask

   task automatic test_random;
      logic [1:0] bresp_o, rresp_o; logic [31:0] dat, wa, ra, wv, er; logic [3:0] ws;
      int wlat, rlat, wi, ri; bit ok1, ok2, ok3;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 16; i++) begin
            wv = $urandom;
            do_write(d, 32'h100 + 32'(4*i), wv, 4'hF, 0, 0, 0, bresp_o, wlat, ok1, ok2);
            mdl_write(d, 32'h100 + 32'(4*i), wv, 4'hF);
         end
         for (int it = 0; it < 25; it++) begin
            wi = $urandom_range(0, 15);
            ri = (wi + $urandom_range(1, 15)) % 16;
            wa = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 255) * 4)
                                             : 32'h100 + 32'(4*wi);
            ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FF00 : 32'h100 + 32'(4*ri);
            wa = wa | 32'($urandom_range(0, 3));
            ra = ra | 32'($urandom_range(0, 3));
            wv = $urandom; ws = 4'($urandom_range(0, 15));
            er = exp_rdata(d, ra);
            fork
               do_write(d, wa, wv, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                        bresp_o, wlat, ok1, ok2);
               do_read(d, ra, $urandom_range(0, 2), dat, rresp_o, rlat, ok3);
            join
            mdl_write(d, wa, wv, ws);
            checks++;
            if (bresp_o !== exp_resp(wa) || wlat !== 1 || ok1 !== 1'b1) begin
               failures++;
               $display("FAIL rand_write d%0d %h: got bresp %b lat %0d order %0d expected %b/1/1",
                        d, wa, bresp_o, wlat, ok1, exp_resp(wa));
            end
            checks++;
            if (dat !== er || rresp_o !== exp_resp(ra) || rlat !== lat_of(d)) begin
               failures++;
               $display("FAIL rand_read d%0d %h: got %h/%b lat %0d expected %h/%b lat %0d",
                        d, ra, dat, rresp_o, rlat, er, exp_resp(ra), lat_of(d));
            end
         end
      end
   endtask

   task automatic test_reset_midop;
      logic [1:0] resp; logic [31:0] dat; int lat; bit ok1;
      awaddr[0] = 32'h104; wdata[0] = 32'h5A5A_A5A5; wstrb[0] = 4'hF;
      awvalid[0] = 1'b1; wvalid[0] = 1'b1;
      araddr[1] = 32'h104; arvalid[1] = 1'b1;
      @(negedge clk);
      awvalid[0] = 1'b0; wvalid[0] = 1'b0; arvalid[1] = 1'b0;
      mdl_write(0, 32'h104, 32'h5A5A_A5A5, 4'hF);
      @(negedge clk);
      checks++;
      if (bvalid[0] !== 1'b1 || rvalid[1] !== 1'b0) begin
         failures++; $display("FAIL midop_setup: got bvalid %b rvalid %b expected 1 0", bvalid[0], rvalid[1]);
      end
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({awready[d], wready[d], bvalid[d], arready[d], rvalid[d], bresp[d], rresp[d], rdata[d]} !== '0) begin
            failures++;
            $display("FAIL midop_reset_outputs d%0d: got bvalid %b rvalid %b rdata %h expected all 0",
                     d, bvalid[d], rvalid[d], rdata[d]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({awready[d], wready[d], arready[d]} !== 3'b000) begin
            failures++; $display("FAIL midop_first_cycle d%0d: got %b expected 000", d, {awready[d], wready[d], arready[d]});
         end
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({awready[d], wready[d], arready[d], bvalid[d], rvalid[d]} !== 5'b11100) begin
               failures++;
               $display("FAIL midop_after d%0d cyc %0d: got rdy %b%b%b bvalid %b rvalid %b expected 111 0 0",
                        d, c, awready[d], wready[d], arready[d], bvalid[d], rvalid[d]);
            end
         end
      end
      do_read(0, 32'h104, 0, dat, resp, lat, ok1);
      checks++;
      if (dat !== exp_rdata(0, 32'h104)) begin
         failures++; $display("FAIL midop_ram_kept: got %h expected %h", dat, exp_rdata(0, 32'h104));
      end
   endtask

   initial begin
      awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
      awvalid = '0; wvalid = '0; bready = '0; arvalid = '0; rready = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_w_before_aw();
      test_out_of_range();
      test_backpressure();
      test_back_to_back();
      test_latency4_collision();
      test_random();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
